// File: rtl/rv_core_pkg.sv
// Shared core types and defaults for the PC sequencer.
// Includes the state encoding and the alignment helper used by PC_MISALIGN_TRAP_EN builds.
package rv_core_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } pc_state_e;

    // A fetch target is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-pc select: redirect > hold > increment, plus the alignment check.
// With PC_MISALIGN_TRAP_EN the raw target passes and is flagged; otherwise its low bits are cleared.
module pc_next_mux
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            hold,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] target;

`ifdef PC_MISALIGN_TRAP_EN
    assign target       = redirect_target;
    assign misaligned_c = redirect_valid && is_misaligned(redirect_target[1:0]);
`else
    assign target       = redirect_target & ~XLEN'(3);
    assign misaligned_c = 1'b0;
`endif

    // Increment wraps modulo 2^XLEN.
    always_comb begin
        next_pc_c = pc + XLEN'(PC_STEP);
        if (redirect_valid) begin
            next_pc_c = target;
        end else if (hold) begin
            next_pc_c = pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer driving a req/ack instruction-memory port with redirect squash.
// PC_MISALIGN_TRAP_EN enables the TRAP state for misaligned redirect targets.
module pc_sequencer
    import rv_core_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_step,
    output logic            trap
);

    pc_state_e       state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] pending_pc, pending_d;
    logic            squash, squash_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] next_pc;
    logic            next_mis;
    logic            pending_mis;
    logic            mux_hold;

    // IDLE keeps the reset pc so the first fetch is RESET_PC.
    assign mux_hold = stall || (state == IDLE);

    pc_next_mux #(
        .XLEN   (XLEN),
        .PC_STEP(PC_STEP)
    ) u_next (
        .pc             (pc),
        .hold           (mux_hold),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .next_pc_c      (next_pc),
        .misaligned_c   (next_mis)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign pending_mis = is_misaligned(pending_pc[1:0]);
`else
    assign pending_mis = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        pending_d = pending_pc;
        squash_d  = squash;
        case (state)
            IDLE: begin
                pc_d    = next_pc;
                state_d = next_mis ? TRAP : REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    if (squash) begin
                        // Squashed return: a same-cycle redirect still overrides the pending target.
                        squash_d = 1'b0;
                        pc_d     = redirect_valid ? next_pc : pending_pc;
                        state_d  = (redirect_valid ? next_mis : pending_mis) ? TRAP : REQ;
                    end else begin
                        pc_d = next_pc;
                        if (next_mis) begin
                            state_d = TRAP;
                        end else if (stall && !redirect_valid) begin
                            state_d = HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    // Outstanding request cannot be cancelled; remember where to go after it returns.
                    pending_d = next_pc;
                    squash_d  = 1'b1;
                end
            end
            HOLD: begin
                pc_d = next_pc;
                if (next_mis) begin
                    state_d = TRAP;
                end else if (redirect_valid || !stall) begin
                    state_d = REQ;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        trap_d = (state_d == TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pending_pc   <= RESET_PC;
            squash       <= 1'b0;
            trap_q       <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            pc_plus_step <= RESET_PC + XLEN'(PC_STEP);
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            pending_pc   <= pending_d;
            squash       <= squash_d;
            trap_q       <= trap_d;
            imem_req     <= (state_d == REQ);
            imem_addr    <= pc_d;
            pc_plus_step <= pc_d + XLEN'(PC_STEP);
        end
    end

    assign instr_valid = (state == REQ) && imem_ack && !squash;
    assign pc_out      = pc;
    assign trap        = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a fetch-transaction reference model.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_step;
    logic        trap;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_ack;
    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_pps;
    logic        hi_trap;

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding fetch at most.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_idle;
    bit          m_fetch;
    bit          m_squash;
    bit          m_trap;

    pc_sequencer u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .instr_valid    (instr_valid),
        .pc_out         (pc_out),
        .pc_plus_step   (pc_plus_step),
        .trap           (trap)
    );

    assign hi_ack = hi_req;

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_target(32'h0),
        .imem_req       (hi_req),
        .imem_addr      (hi_addr),
        .imem_ack       (hi_ack),
        .instr_valid    (hi_valid),
        .pc_out         (hi_pc),
        .pc_plus_step   (hi_pps),
        .trap           (hi_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fix(input logic [31:0] t);
        return TRAP_EN ? t : (t & 32'hFFFF_FFFC);
    endfunction

    function automatic bit bad(input logic [31:0] t);
        return TRAP_EN && (t[1:0] != 2'b00);
    endfunction

    task automatic model_step(input bit s, input bit rv, input logic [31:0] t, input bit a);
        logic [31:0] dest;
        if (m_trap) return;
        if (!m_fetch) begin
            if (rv) begin
                m_pc = fix(t);
                if (bad(t)) m_trap = 1'b1;
                else        m_fetch = 1'b1;
            end else if (m_idle) begin
                m_fetch = 1'b1;
            end else if (!s) begin
                m_pc    = m_pc + 32'd4;
                m_fetch = 1'b1;
            end
            m_idle = 1'b0;
        end else if (!a) begin
            if (rv) begin
                m_pend   = fix(t);
                m_squash = 1'b1;
            end
        end else if (m_squash) begin
            m_squash = 1'b0;
            dest     = rv ? fix(t) : m_pend;
            m_pc     = dest;
            if (bad(dest)) begin
                m_trap  = 1'b1;
                m_fetch = 1'b0;
            end
        end else if (rv) begin
            m_pc = fix(t);
            if (bad(t)) begin
                m_trap  = 1'b1;
                m_fetch = 1'b0;
            end
        end else if (s) begin
            m_fetch = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic cycle(input bit s, input bit rv, input logic [31:0] t, input bit a);
        @(negedge clk);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        imem_ack        = a && m_fetch;
        #1;
        check("imem_req", 32'(imem_req), 32'(m_fetch));
        if (m_fetch) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_fetch && imem_ack && !m_squash));
        check("pc_out", pc_out, m_pc);
        check("pc_plus_step", pc_plus_step, m_pc + 32'd4);
        check("trap", 32'(trap), 32'(m_trap));
        model_step(s, rv, t, imem_ack);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_pps", pc_plus_step, 32'd4);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_pc     = 32'd0;
        m_pend   = 32'd0;
        m_idle   = 1'b1;
        m_fetch  = 1'b0;
        m_squash = 1'b0;
        m_trap   = 1'b0;
    endtask

    initial begin
        logic [31:0] he;
        logic [31:0] tgt;
        int          trap_cnt;
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ack        = 1'b0;
        do_reset();

        // Zero-wait sequential fetch, plus wraparound on the high-reset instance.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (i >= 2) begin
                check("seq_addr", imem_addr, 32'((i - 2) * 4));
                check("seq_valid", 32'(instr_valid), 32'd1);
            end
            if (i == 1) begin
                check("hi_idle_req", 32'(hi_req), 32'd0);
            end else if (i <= 4) begin
                he = 32'hFFFF_FFF8 + 32'((i - 2) * 4);
                check("hi_addr", hi_addr, he);
                check("hi_valid", 32'(hi_valid), 32'd1);
                check("hi_pc", hi_pc, he);
                check("hi_pps", hi_pps, he + 32'd4);
                check("hi_trap", 32'(hi_trap), 32'd0);
            end
        end

        // Redirect while 0x10 is outstanding; ack on the third cycle is squashed.
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        check("sq_addr0", imem_addr, 32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("sq_addr1", imem_addr, 32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("sq_addr2", imem_addr, 32'h10);
        check("sq_valid", 32'(instr_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("sq_next", imem_addr, 32'h200);
        check("sq_next_valid", 32'(instr_valid), 32'd1);

        // Redirect coincident with ack keeps the returned instruction.
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        cycle(1'b0, 1'b1, 32'h80, 1'b1);
        check("rd_valid", 32'(instr_valid), 32'd1);
        check("rd_pc", pc_out, 32'h40);
        check("rd_pps", pc_plus_step, 32'h44);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_next", imem_addr, 32'h80);

        // Stall after delivering 0x8, then resume at 0xC.
        cycle(1'b0, 1'b1, 32'h8, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("st_valid", 32'(instr_valid), 32'd1);
        check("st_pc", pc_out, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            check("st_req", 32'(imem_req), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("st_resume", imem_addr, 32'hC);
        // Redirect during stall resumes at the target despite stall.
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("st_redir_req", 32'(imem_req), 32'd1);
        check("st_redir", imem_addr, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect.
        cycle(1'b0, 1'b1, 32'h102, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_trap", 32'(trap), 32'd1);
        check("mis_pc", pc_out, 32'h102);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check("mis_req", 32'(imem_req), 32'd0);
        end
`else
        check("mis_addr", imem_addr, 32'h100);
        check("mis_trap0", 32'(trap), 32'd0);
`endif

        // Reset with a request outstanding drops it immediately.
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("mid_req", 32'(imem_req), 32'd1);
        do_reset();

        // Randomized traffic.
        trap_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0 || trap_cnt > 20) begin
                do_reset();
                trap_cnt = 0;
            end else begin
                case ($urandom_range(0, 15))
                    0:       tgt = 32'hFFFF_FFFC - 32'($urandom_range(0, 3) * 4);
                    1:       tgt = $urandom;
                    default: tgt = $urandom & 32'hFFFF_FFFC;
                endcase
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt,
                      $urandom_range(0, 1) == 1);
                trap_cnt = m_trap ? trap_cnt + 1 : 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
